// File: rtl/flags_pkg.sv
// Shared flag bit positions and default sizing for the status-flags register.
package flags_pkg;
  localparam int FLAG_Z     = 0;
  localparam int FLAG_C     = 1;
  localparam int FLAG_N     = 2;
  localparam int FLAG_V     = 3;
  localparam int NFLAGS_DEF = 4;
  localparam int DEPTH_DEF  = 4;
endpackage

// File: rtl/flags_stack.sv
// DEPTH x NFLAGS LIFO holding saved flag contexts; state updates one cycle after the strobe.
// No backpressure: misuse is dropped and recorded in sticky ovf/unf flags.
module flags_stack
  import flags_pkg::*;
#(
  parameter int NFLAGS = NFLAGS_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [NFLAGS-1:0]          i_wr_data,
  output logic [NFLAGS-1:0]          o_top,
  output logic                       o_pop_vld,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_ovf_err,
  output logic                       o_unf_err
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [NFLAGS-1:0] r_stack [DEPTH];
  logic [CW-1:0]     r_count;
  logic              r_ovf_err;
  logic              r_unf_err;

  logic              w_full;
  logic              w_empty;
  logic              w_pop_vld;
  logic              w_wr_en;
  logic              w_inc;
  logic              w_dec;
  logic [CW-1:0]     w_top_idx;
  logic [CW-1:0]     w_wr_idx;
  logic [NFLAGS-1:0] w_top;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop_vld = i_pop & ~w_empty;
  assign w_top_idx = r_count - CW'(1);
  // Push+pop on a non-empty stack overwrites the top in place (swap).
  assign w_wr_en   = i_push & (i_pop | ~w_full);
  assign w_wr_idx  = w_pop_vld ? w_top_idx : r_count;
  assign w_inc     = i_push & ~w_pop_vld & ~w_full;
  assign w_dec     = w_pop_vld & ~i_push;

  always_comb begin
    w_top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_top_idx == CW'(i)) w_top = r_stack[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_en && (w_wr_idx == CW'(i))) r_stack[i] <= i_wr_data;
      end
      if (w_inc)      r_count <= r_count + CW'(1);
      else if (w_dec) r_count <= r_count - CW'(1);
      if (i_push && !i_pop && w_full) r_ovf_err <= 1'b1;
      if (i_pop && w_empty)           r_unf_err <= 1'b1;
    end
  end

  assign o_top     = w_top;
  assign o_pop_vld = w_pop_vld;
  assign o_count   = r_count;
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_ovf_err = r_ovf_err;
  assign o_unf_err = r_unf_err;
endmodule

// File: rtl/flags_ctx_reg.sv
// Status-flags register with masked update, same-cycle bypass (flags_out) and a context stack.
// flags_q/count/errors lag one cycle; strobes are accepted every cycle, misuse sets sticky errors.
module flags_ctx_reg
  import flags_pkg::*;
#(
  parameter int NFLAGS = NFLAGS_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       upd_en,
  input  logic [NFLAGS-1:0]          upd_mask,
  input  logic [NFLAGS-1:0]          upd_data,
  input  logic                       push,
  input  logic                       pop,
  output logic [NFLAGS-1:0]          flags_q,
  output logic [NFLAGS-1:0]          flags_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf_err,
  output logic                       unf_err
);
  logic [NFLAGS-1:0] r_flags;
  logic [NFLAGS-1:0] w_top;
  logic              w_pop_vld;
  logic [NFLAGS-1:0] w_base;
  logic [NFLAGS-1:0] w_next;

  // The stack always saves the pre-update flags, never the merged next value.
  flags_stack #(
    .NFLAGS (NFLAGS),
    .DEPTH  (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .i_push    (push),
    .i_pop     (pop),
    .i_wr_data (r_flags),
    .o_top     (w_top),
    .o_pop_vld (w_pop_vld),
    .o_count   (count),
    .o_full    (full),
    .o_empty   (empty),
    .o_ovf_err (ovf_err),
    .o_unf_err (unf_err)
  );

  assign w_base = w_pop_vld ? w_top : r_flags;
  assign w_next = upd_en ? ((w_base & ~upd_mask) | (upd_data & upd_mask)) : w_base;

  always_ff @(posedge clk) begin
    if (rst) r_flags <= '0;
    else     r_flags <= w_next;
  end

  assign flags_q   = r_flags;
  assign flags_out = w_next;
endmodule

// File: tb/tb_flags_ctx_reg.sv
// Directed-vector bench for flags_ctx_reg (NFLAGS=4, DEPTH=4) with hand-computed expectations.
module tb_flags_ctx_reg;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       upd_en = 1'b0;
  logic [3:0] upd_mask = '0;
  logic [3:0] upd_data = '0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [3:0] flags_q;
  logic [3:0] flags_out;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       ovf_err;
  logic       unf_err;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  flags_ctx_reg #(.NFLAGS(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .upd_en    (upd_en),
    .upd_mask  (upd_mask),
    .upd_data  (upd_data),
    .push      (push),
    .pop       (pop),
    .flags_q   (flags_q),
    .flags_out (flags_out),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ovf_err   (ovf_err),
    .unf_err   (unf_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs mid-cycle; leaves 1ns for flags_out to settle before checks.
  task automatic set_in(input logic u, input logic [3:0] m, input logic [3:0] d,
                        input logic ps, input logic pp);
    upd_en = u; upd_mask = m; upd_data = d; push = ps; pop = pp;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    upd_en = 1'b0; upd_mask = '0; upd_data = '0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] fq, input logic [2:0] cnt,
                           input logic f, input logic e, input logic ov, input logic un);
    chk({tag, ".flags_q"}, 32'(flags_q), 32'(fq));
    chk({tag, ".count"},   32'(count),   32'(cnt));
    chk({tag, ".full"},    32'(full),    32'(f));
    chk({tag, ".empty"},   32'(empty),   32'(e));
    chk({tag, ".ovf"},     32'(ovf_err), 32'(ov));
    chk({tag, ".unf"},     32'(unf_err), 32'(un));
  endtask

  initial begin
    // Reset
    tick();
    chk_state("reset", 4'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    // Masked update and bypass
    set_in(1'b1, 4'b0011, 4'b1111, 1'b0, 1'b0);
    chk("upd.bypass", 32'(flags_out), 32'h3);
    chk("upd.q_before", 32'(flags_q), 32'h0);
    tick();
    chk("upd.q", 32'(flags_q), 32'h3);

    // Push saves pre-update flags
    set_in(1'b1, 4'hF, 4'h5, 1'b0, 1'b0); tick();
    chk("set5", 32'(flags_q), 32'h5);
    set_in(1'b1, 4'hF, 4'hA, 1'b1, 1'b0);
    chk("pushupd.bypass", 32'(flags_out), 32'hA);
    tick();
    chk("pushupd.q", 32'(flags_q), 32'hA);
    chk("pushupd.count", 32'(count), 32'd1);
    set_in(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("pop5.bypass", 32'(flags_out), 32'h5);
    tick();
    chk_state("pop5", 4'h5, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Fill to full, overflow, drain in reverse
    set_in(1'b1, 4'hF, 4'h1, 1'b0, 1'b0); tick();
    set_in(1'b1, 4'hF, 4'h2, 1'b1, 1'b0); tick();
    set_in(1'b1, 4'hF, 4'h3, 1'b1, 1'b0); tick();
    set_in(1'b1, 4'hF, 4'h4, 1'b1, 1'b0); tick();
    set_in(1'b1, 4'hF, 4'h8, 1'b1, 1'b0); tick();
    chk_state("fill4", 4'h8, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 4'hF, 4'h9, 1'b1, 1'b0); tick();
    chk_state("ovf", 4'h9, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    set_in(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("pop1.bypass", 32'(flags_out), 32'h4);
    tick();
    chk_state("pop1", 4'h4, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    set_in(1'b0, 4'h0, 4'h0, 1'b0, 1'b1); tick();
    chk_state("pop2", 4'h3, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    // Pop merged with a partial update: top 2 with bit0 forced -> 3
    set_in(1'b1, 4'b0001, 4'b0001, 1'b0, 1'b1);
    chk("pop3.bypass", 32'(flags_out), 32'h3);
    tick();
    chk_state("pop3", 4'h3, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    set_in(1'b0, 4'h0, 4'h0, 1'b0, 1'b1); tick();
    chk_state("pop4", 4'h1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Pop on empty
    set_in(1'b1, 4'hF, 4'h6, 1'b0, 1'b0); tick();
    set_in(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("unf.bypass", 32'(flags_out), 32'h6);
    tick();
    chk_state("unf", 4'h6, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Swap: count=2, top=3, flags_q=C
    set_in(1'b1, 4'hF, 4'h3, 1'b1, 1'b0); tick();
    set_in(1'b1, 4'hF, 4'hC, 1'b1, 1'b0); tick();
    chk("preswap.q", 32'(flags_q), 32'hC);
    chk("preswap.count", 32'(count), 32'd2);
    set_in(1'b0, 4'h0, 4'h0, 1'b1, 1'b1);
    chk("swap.bypass", 32'(flags_out), 32'h3);
    tick();
    chk("swap.q", 32'(flags_q), 32'h3);
    chk("swap.count", 32'(count), 32'd2);
    set_in(1'b0, 4'h0, 4'h0, 1'b0, 1'b1); tick();
    chk("swap.top", 32'(flags_q), 32'hC);
    chk("swap.count1", 32'(count), 32'd1);
    set_in(1'b0, 4'h0, 4'h0, 1'b0, 1'b1); tick();
    chk("swap.bottom", 32'(flags_q), 32'h6);

    // Mid-sequence reset with count=3 and errors set; rst overrides strobes
    set_in(1'b0, 4'h0, 4'h0, 1'b1, 1'b0); tick();
    set_in(1'b0, 4'h0, 4'h0, 1'b1, 1'b0); tick();
    set_in(1'b0, 4'h0, 4'h0, 1'b1, 1'b0); tick();
    chk_state("prerst", 4'h6, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    set_in(1'b1, 4'hF, 4'h5, 1'b1, 1'b0);
    chk("rst.bypass", 32'(flags_out), 32'h5);
    tick();
    rst = 1'b0;
    chk_state("rst", 4'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Push+pop on empty: pop ignored (unf), push performed
    set_in(1'b1, 4'hF, 4'h7, 1'b0, 1'b0); tick();
    set_in(1'b0, 4'h0, 4'h0, 1'b1, 1'b1);
    chk("pp_empty.bypass", 32'(flags_out), 32'h7);
    tick();
    chk_state("pp_empty", 4'h7, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    set_in(1'b1, 4'hF, 4'h0, 1'b0, 1'b0); tick();
    set_in(1'b0, 4'h0, 4'h0, 1'b0, 1'b1); tick();
    chk_state("pp_empty.pop", 4'h7, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
